tc0480scp_rom_fetch: RTL and testbench



---
 rtl/tc0480scp_pkg.sv | 16 +
 rtl/tc0480scp_rom_fetch_if.sv | 24 ++
 rtl/tc0480scp_rom_tag_cache.sv | 53 +++++
 rtl/tc0480scp_rom_fetch.sv | 126 ++++++++++++
 tb/tb_tc0480scp_rom_fetch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tc0480scp_pkg.sv
// Shared types and constants for the TC0480SCP tile-ROM fetch path.
package tc0480scp_pkg;

    localparam int unsigned ROM_ROW_BYTES = 8;
    localparam int unsigned ROM_ADDR_W    = 22;
    localparam int unsigned ROM_TAG_W     = ROM_ADDR_W - $clog2(ROM_ROW_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFetchLo,
        StFetchHi,
        StFill
    } rom_fetch_state_t;

endpackage

// File: rtl/tc0480scp_rom_fetch_if.sv
// ROM request port plus SDRAM read port; master is the requester / SDRAM model side.
interface tc0480scp_rom_fetch_if #(
    parameter int unsigned SDR_AW = 26
);
    logic [21:0]       rom_address;
    logic              rom_req;
    logic              rom_ack;
    logic [63:0]       rom_data;
    logic              flush;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_ack;
    logic [31:0]       sdr_data;

    modport master (
        output rom_address, rom_req, flush, sdr_ack, sdr_data,
        input  rom_ack, rom_data, sdr_addr, sdr_req
    );

    modport slave (
        input  rom_address, rom_req, flush, sdr_ack, sdr_data,
        output rom_ack, rom_data, sdr_addr, sdr_req
    );
endinterface

// File: rtl/tc0480scp_rom_tag_cache.sv
// Fully-associative row cache: register arrays, parallel tag match, round-robin refill.
module tc0480scp_rom_tag_cache
    import tc0480scp_pkg::*;
#(
    parameter int unsigned Entries = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [ROM_TAG_W-1:0] lookup_tag_i,
    output logic                 hit_o,
    output logic [63:0]          hit_data_o,
    input  logic                 wr_en_i,
    input  logic [ROM_TAG_W-1:0] wr_tag_i,
    input  logic [63:0]          wr_data_i
);
    localparam int unsigned PtrW = $clog2(Entries);

    logic [ROM_TAG_W-1:0] tag_q  [Entries];
    logic [63:0]          data_q [Entries];
    logic [Entries-1:0]   valid_q;
    logic [PtrW-1:0]      ptr_q;

    // Flush beats a coincident write so a row fetched across a reload never turns valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (wr_en_i) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[ptr_q]  <= wr_tag_i;
            data_q[ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < Entries; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[i];
            end
        end
    end

endmodule

// File: rtl/tc0480scp_rom_fetch.sv
// Toggle-handshake ROM fetch adapter: row cache in front of two-word SDRAM reads.
module tc0480scp_rom_fetch
    import tc0480scp_pkg::*;
#(
    parameter int unsigned       CACHE_ENTRIES = 4,
    parameter int unsigned       SDR_AW        = 26,
    parameter logic [SDR_AW-1:0] BASE_ADDR     = '0
) (
    input logic                  clk,
    input logic                  reset_n,
    tc0480scp_rom_fetch_if.slave bus
);
    rom_fetch_state_t     state_q, state_d;
    logic [ROM_TAG_W-1:0] tag_q, tag_d;
    logic [63:0]          rom_data_q, rom_data_d;
    logic [SDR_AW-1:0]    sdr_addr_q, sdr_addr_d;
    logic                 rom_ack_q, rom_ack_d;
    logic                 sdr_req_q, sdr_req_d;
    logic                 drop_q, drop_d;

    logic        hit;
    logic [63:0] hit_data;
    logic        cache_we;
    logic        rom_pending;
    logic        sdr_done;
    logic        lookup_hit;

    assign rom_pending = bus.rom_req != rom_ack_q;
    assign sdr_done    = bus.sdr_ack == sdr_req_q;
    assign lookup_hit  = hit && !bus.flush;

    tc0480scp_rom_tag_cache #(
        .Entries (CACHE_ENTRIES)
    ) u_cache (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .flush_i      (bus.flush),
        .lookup_tag_i (tag_q),
        .hit_o        (hit),
        .hit_data_o   (hit_data),
        .wr_en_i      (cache_we),
        .wr_tag_i     (tag_q),
        .wr_data_i    (rom_data_q)
    );

    // Reset mirrors the peer toggles so neither handshake is left pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tag_q      <= '0;
            rom_data_q <= '0;
            sdr_addr_q <= '0;
            rom_ack_q  <= bus.rom_req;
            sdr_req_q  <= bus.sdr_ack;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            rom_data_q <= rom_data_d;
            sdr_addr_q <= sdr_addr_d;
            rom_ack_q  <= rom_ack_d;
            sdr_req_q  <= sdr_req_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (rom_pending) state_d = StLookup;
            StLookup:  state_d = lookup_hit ? StIdle : StFetchLo;
            StFetchLo: if (sdr_done) state_d = StFetchHi;
            StFetchHi: if (sdr_done) state_d = StFill;
            StFill:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_d      = tag_q;
        rom_data_d = rom_data_q;
        sdr_addr_d = sdr_addr_q;
        rom_ack_d  = rom_ack_q;
        sdr_req_d  = sdr_req_q;
        drop_d     = drop_q;
        cache_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (rom_pending) tag_d = bus.rom_address[21:3];
            end
            StLookup: begin
                if (lookup_hit) begin
                    rom_data_d = hit_data;
                    rom_ack_d  = ~rom_ack_q;
                end else begin
                    sdr_addr_d = BASE_ADDR + SDR_AW'({tag_q, 3'b000});
                    sdr_req_d  = ~sdr_req_q;
                end
            end
            StFetchLo: begin
                drop_d = drop_q | bus.flush;
                if (sdr_done) begin
                    rom_data_d[31:0] = bus.sdr_data;
                    sdr_addr_d       = sdr_addr_q + SDR_AW'(4);
                    sdr_req_d        = ~sdr_req_q;
                end
            end
            StFetchHi: begin
                drop_d = drop_q | bus.flush;
                if (sdr_done) rom_data_d[63:32] = bus.sdr_data;
            end
            StFill: begin
                cache_we  = !drop_q;
                rom_ack_d = ~rom_ack_q;
            end
            default: ;
        endcase
    end

    assign bus.rom_ack  = rom_ack_q;
    assign bus.rom_data = rom_data_q;
    assign bus.sdr_addr = sdr_addr_q;
    assign bus.sdr_req  = sdr_req_q;

endmodule

// File: tb/tb_tc0480scp_rom_fetch.sv
// Directed bench: reset, miss/hit, eviction, flush mid-fetch, base-address wrap.
module tb_tc0480scp_rom_fetch;
    import tc0480scp_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    tc0480scp_rom_fetch_if #(.SDR_AW(26)) bus1 ();
    tc0480scp_rom_fetch_if #(.SDR_AW(26)) bus2 ();

    tc0480scp_rom_fetch #(
        .CACHE_ENTRIES (4),
        .SDR_AW        (26),
        .BASE_ADDR     (26'h0)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    tc0480scp_rom_fetch #(
        .CACHE_ENTRIES (4),
        .SDR_AW        (26),
        .BASE_ADDR     (26'h3FFFFF8)
    ) u_dut_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sdr_word(input logic [25:0] a);
        if (a == 26'h100) return 32'h11223344;
        if (a == 26'h104) return 32'h55667788;
        return {6'b101010, a};
    endfunction

    function automatic logic [63:0] row_word(input logic [21:0] ra);
        logic [25:0] a;
        a = {4'b0000, ra[21:3], 3'b000};
        return {sdr_word(a + 26'd4), sdr_word(a)};
    endfunction

    // SDRAM model for bus1: logs each read address, answers two clocks later.
    logic [25:0] sdr_log[$];
    initial begin
        logic [25:0] a;
        bus1.sdr_ack  = 1'b1;
        bus1.sdr_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reset_n && (bus1.sdr_req !== bus1.sdr_ack)) begin
                a = bus1.sdr_addr;
                sdr_log.push_back(a);
                repeat (2) @(posedge clk);
                #1;
                bus1.sdr_data = sdr_word(a);
                bus1.sdr_ack  = bus1.sdr_req;
            end
        end
    end

    task automatic wait_ack1(output int cyc);
        cyc = 0;
        while ((bus1.rom_ack !== bus1.rom_req) && (cyc < 100)) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 100) check_eq("ack_timeout", bus1.rom_ack, bus1.rom_req);
    endtask

    task automatic fetch1(input logic [21:0] a, output logic [63:0] d, output int cyc);
        bus1.rom_address = a;
        bus1.rom_req     = ~bus1.rom_req;
        wait_ack1(cyc);
        d = bus1.rom_data;
    endtask

    task automatic wait_sdr2();
        int cyc;
        cyc = 0;
        while ((bus2.sdr_req === bus2.sdr_ack) && (cyc < 100)) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 100) check_eq("sdr2_timeout", bus2.sdr_req, ~bus2.sdr_ack);
    endtask

    initial begin
        logic [63:0] d;
        int          cyc;
        int          n0;
        logic [21:0] ra;

        bus1.rom_req = 1'b1; bus1.rom_address = '0; bus1.flush = 1'b0;
        bus2.rom_req = 1'b0; bus2.rom_address = '0; bus2.flush = 1'b0;
        bus2.sdr_ack = 1'b0; bus2.sdr_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rom_ack", bus1.rom_ack, 1'b1);
        check_eq("rst_sdr_req", bus1.sdr_req, 1'b1);
        check_eq("rst_rom_data", bus1.rom_data, 64'h0);
        check_eq("rst_sdr_addr", bus1.sdr_addr, 64'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_no_sdr_traffic", sdr_log.size(), 0);
        check_eq("rst_ack_held", bus1.rom_ack, 1'b1);

        // Cold miss
        n0 = sdr_log.size();
        fetch1(22'h000100, d, cyc);
        check_eq("miss_data", d, 64'h5566778811223344);
        check_eq("miss_nreads", sdr_log.size() - n0, 2);
        check_eq("miss_addr_lo", sdr_log[n0], 26'h100);
        check_eq("miss_addr_hi", sdr_log[n0+1], 26'h104);

        // Same row, different low bits
        n0 = sdr_log.size();
        fetch1(22'h000105, d, cyc);
        check_eq("hit_data", d, 64'h5566778811223344);
        check_eq("hit_latency", cyc, 2);
        check_eq("hit_nreads", sdr_log.size() - n0, 0);
        check_eq("hit_sdr_idle", bus1.sdr_req, bus1.sdr_ack);

        // Clean slate, then five distinct rows into four entries
        bus1.flush = 1'b1;
        @(posedge clk); #1;
        bus1.flush = 1'b0;
        n0 = sdr_log.size();
        for (int i = 0; i < 5; i++) begin
            ra = 22'h001000 + 22'(i * 8);
            fetch1(ra, d, cyc);
            check_eq("fill_data", d, row_word(ra));
        end
        check_eq("fill_nreads", sdr_log.size() - n0, 10);
        n0 = sdr_log.size();
        fetch1(22'h001008, d, cyc);
        check_eq("second_row_hit_lat", cyc, 2);
        check_eq("second_row_hit_data", d, row_word(22'h001008));
        check_eq("second_row_nreads", sdr_log.size() - n0, 0);
        n0 = sdr_log.size();
        fetch1(22'h001000, d, cyc);
        check_eq("evicted_row_nreads", sdr_log.size() - n0, 2);
        check_eq("evicted_row_data", d, row_word(22'h001000));
        fetch1(22'h001010, d, cyc);
        check_eq("third_row_hit_lat", cyc, 2);

        // Flush while the upper word is outstanding
        bus1.rom_address = 22'h000200;
        bus1.rom_req     = ~bus1.rom_req;
        cyc = 0;
        while ((bus1.sdr_addr !== 26'h204) && (cyc < 100)) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("flush_reach_hi", bus1.sdr_addr, 26'h204);
        bus1.flush = 1'b1;
        @(posedge clk); #1;
        bus1.flush = 1'b0;
        wait_ack1(cyc);
        check_eq("flush_inflight_data", bus1.rom_data, row_word(22'h000200));
        n0 = sdr_log.size();
        fetch1(22'h000200, d, cyc);
        check_eq("flush_refetch_nreads", sdr_log.size() - n0, 2);
        check_eq("flush_refetch_data", d, row_word(22'h000200));

        // Base address wraps modulo 2^26
        bus2.rom_address = 22'h000008;
        bus2.rom_req     = ~bus2.rom_req;
        wait_sdr2();
        check_eq("wrap_addr_lo", bus2.sdr_addr, 26'h0000000);
        bus2.sdr_data = 32'hCAFE0001;
        bus2.sdr_ack  = bus2.sdr_req;
        @(posedge clk); #1;
        wait_sdr2();
        check_eq("wrap_addr_hi", bus2.sdr_addr, 26'h0000004);
        bus2.sdr_data = 32'hCAFE0002;
        bus2.sdr_ack  = bus2.sdr_req;
        cyc = 0;
        while ((bus2.rom_ack !== bus2.rom_req) && (cyc < 100)) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("wrap_ack", bus2.rom_ack, bus2.rom_req);
        check_eq("wrap_data", bus2.rom_data, 64'hCAFE0002CAFE0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
